// File: rtl/wb_regfile_pkg.sv
// Shared write-back definitions for the register file, the MEM/WB register and the hazard unit.
// WB control bundles are packed MSB-first as {RegWrite, MemtoReg, PCtoReg, Halt}.
package wb_regfile_pkg;

   localparam int DATA_W    = 16;
   localparam int REG_IDX_W = 4;
   localparam int NUM_REGS  = 1 << REG_IDX_W;
   localparam int WB_CTRL_W = 4;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
      logic pc_to_reg;
      logic halt;
   } wb_ctrl_t;

   // PC has priority over load data; the ALU result is the default.
   function automatic logic [DATA_W-1:0] wb_select(
      input wb_ctrl_t          ctrl,
      input logic [DATA_W-1:0] alu,
      input logic [DATA_W-1:0] mem,
      input logic [DATA_W-1:0] pc
   );
      logic [DATA_W-1:0] sel;
      sel = alu;
      if (ctrl.pc_to_reg)
         sel = pc;
      else if (ctrl.mem_to_reg)
         sel = mem;
      return sel;
   endfunction

endpackage

// File: rtl/wb_regfile_bit16reg.sv
// One architectural register: 16-bit storage with write enable and async clear.
module Bit16Reg
   import wb_regfile_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              write_en,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (write_en)
         q <= d;
   end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage register file: 16 x 16-bit registers, two bypassed read ports,
// sticky halt and a saturating count of committed writes.
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter bit ZERO_REG = 1'b1
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 RegWrite,
   input  logic                 MemtoReg,
   input  logic                 PCtoReg,
   input  logic                 Halt,
   input  logic [DATA_W-1:0]    reg_data,
   input  logic [DATA_W-1:0]    dmem_data,
   input  logic [DATA_W-1:0]    PC,
   input  logic [REG_IDX_W-1:0] DstReg,
   input  logic [REG_IDX_W-1:0] SrcReg1,
   input  logic [REG_IDX_W-1:0] SrcReg2,
   output logic [DATA_W-1:0]    SrcData1,
   output logic [DATA_W-1:0]    SrcData2,
   output logic [DATA_W-1:0]    wb_data,
   output logic                 halted,
   output logic [DATA_W-1:0]    write_count
);

   wb_ctrl_t          ctrl;
   logic              commit;
   logic              halted_q;
   logic [DATA_W-1:0] wcnt_q;
   logic [DATA_W-1:0] rf_q [NUM_REGS];

   function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
      return (v == '1) ? v : v + DATA_W'(1);
   endfunction

   // Zero register masks the bypass too, so a write aimed at r0 never leaks out.
   function automatic logic [DATA_W-1:0] read_port(
      input logic [REG_IDX_W-1:0] idx,
      input logic [DATA_W-1:0]    stored,
      input logic                 wr,
      input logic [REG_IDX_W-1:0] dst,
      input logic [DATA_W-1:0]    wdata
   );
      logic [DATA_W-1:0] r;
      r = stored;
      if (ZERO_REG && idx == '0)
         r = '0;
      else if (wr && idx == dst)
         r = wdata;
      return r;
   endfunction

   assign ctrl    = {RegWrite, MemtoReg, PCtoReg, Halt};
   assign wb_data = wb_select(ctrl, reg_data, dmem_data, PC);
   assign commit  = ctrl.reg_write && !halted_q && !(ZERO_REG && DstReg == '0);

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      logic we;
      assign we = commit && (DstReg == REG_IDX_W'(i));
      Bit16Reg u_reg (
         .clk      (clk),
         .rst      (rst),
         .write_en (we),
         .d        (wb_data),
         .q        (rf_q[i])
      );
   end

   always_comb begin
      SrcData1 = read_port(SrcReg1, rf_q[SrcReg1], commit, DstReg, wb_data);
      SrcData2 = read_port(SrcReg2, rf_q[SrcReg2], commit, DstReg, wb_data);
   end

   // Halt blocks writes only from the following cycle; the HLT cycle's own write still commits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         halted_q <= 1'b0;
         wcnt_q   <= '0;
      end else begin
         if (ctrl.halt)
            halted_q <= 1'b1;
         if (commit)
            wcnt_q <= sat_inc(wcnt_q);
      end
   end

   assign halted      = halted_q;
   assign write_count = wcnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: expectations queued on a scoreboard as stimulus is driven,
// then popped and compared against the DUT outputs.
module tb_wb_regfile;

   logic        clk;
   logic        rst;
   logic        RegWrite, MemtoReg, PCtoReg, Halt;
   logic [15:0] reg_data, dmem_data, PC;
   logic [3:0]  DstReg, SrcReg1, SrcReg2;
   logic [15:0] SrcData1, SrcData2, wb_data, write_count;
   logic        halted;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [15:0] exp;
   } exp_t;

   exp_t sb[$];

   wb_regfile #(.ZERO_REG(1'b1)) dut (
      .clk         (clk),
      .rst         (rst),
      .RegWrite    (RegWrite),
      .MemtoReg    (MemtoReg),
      .PCtoReg     (PCtoReg),
      .Halt        (Halt),
      .reg_data    (reg_data),
      .dmem_data   (dmem_data),
      .PC          (PC),
      .DstReg      (DstReg),
      .SrcReg1     (SrcReg1),
      .SrcReg2     (SrcReg2),
      .SrcData1    (SrcData1),
      .SrcData2    (SrcData2),
      .wb_data     (wb_data),
      .halted      (halted),
      .write_count (write_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation time limit reached");
   end

   task automatic expect_val(input string tag, input logic [15:0] e);
      sb.push_back('{tag, e});
   endtask

   task automatic pop_chk(input logic [15:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty observed=%h expected=none", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.exp)
         else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic bubble();
      RegWrite = 1'b0; MemtoReg = 1'b0; PCtoReg = 1'b0; Halt = 1'b0;
   endtask

   // Advance over one rising edge and land on the following falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      bubble();
      reg_data = 16'h0; dmem_data = 16'h0; PC = 16'h0;
      DstReg = 4'd0; SrcReg1 = 4'd3; SrcReg2 = 4'd7;

      // Reset state
      #3;
      expect_val("rst_count", 16'h0000);   pop_chk(write_count);
      expect_val("rst_halted", 16'h0000);  pop_chk({15'b0, halted});
      expect_val("rst_r3", 16'h0000);      pop_chk(SrcData1);

      // Write then read, first edge after reset release
      @(negedge clk);
      rst = 1'b0;
      RegWrite = 1'b1; DstReg = 4'd3; reg_data = 16'h1234;
      #1;
      expect_val("bypass_r3", 16'h1234);   pop_chk(SrcData1);
      tick();
      bubble(); #1;
      expect_val("read_r3", 16'h1234);     pop_chk(SrcData1);
      expect_val("count_1", 16'h0001);     pop_chk(write_count);

      // Data select priority and same-cycle bypass
      RegWrite = 1'b1; MemtoReg = 1'b1; PCtoReg = 1'b1;
      PC = 16'h0042; dmem_data = 16'hBEEF; reg_data = 16'h1111;
      DstReg = 4'd5; SrcReg2 = 4'd5;
      #1;
      expect_val("sel_pc_bypass", 16'h0042); pop_chk(SrcData2);
      expect_val("wb_pc", 16'h0042);         pop_chk(wb_data);
      tick();
      bubble(); MemtoReg = 1'b1; #1;
      expect_val("wb_mem", 16'hBEEF);        pop_chk(wb_data);
      expect_val("read_r5", 16'h0042);       pop_chk(SrcData2);
      MemtoReg = 1'b0; #1;
      expect_val("wb_alu", 16'h1111);        pop_chk(wb_data);

      // Zero register
      RegWrite = 1'b1; DstReg = 4'd0; reg_data = 16'hFFFF; SrcReg1 = 4'd0;
      #1;
      expect_val("r0_wcycle", 16'h0000);     pop_chk(SrcData1);
      tick();
      bubble(); #1;
      expect_val("r0_after", 16'h0000);      pop_chk(SrcData1);
      expect_val("count_r0", 16'h0002);      pop_chk(write_count);

      // Bubble changes nothing
      reg_data = 16'hDEAD; DstReg = 4'd3; SrcReg1 = 4'd3;
      tick(); #1;
      expect_val("bubble_r3", 16'h1234);     pop_chk(SrcData1);
      expect_val("bubble_count", 16'h0002);  pop_chk(write_count);

      // Halt with a write in the same cycle, then a blocked write
      Halt = 1'b1; RegWrite = 1'b1; DstReg = 4'd7; reg_data = 16'h0007; SrcReg1 = 4'd7;
      tick();
      Halt = 1'b0; RegWrite = 1'b1; DstReg = 4'd7; reg_data = 16'h0099;
      #1;
      expect_val("halted_set", 16'h0001);    pop_chk({15'b0, halted});
      expect_val("halt_nobypass", 16'h0007); pop_chk(SrcData1);
      tick();
      bubble(); #1;
      expect_val("halt_r7", 16'h0007);       pop_chk(SrcData1);
      expect_val("halt_count", 16'h0003);    pop_chk(write_count);
      expect_val("halted_hold", 16'h0001);   pop_chk({15'b0, halted});

      // Async reset between edges while a write to r2 is presented
      RegWrite = 1'b1; DstReg = 4'd2; reg_data = 16'hAAAA; SrcReg2 = 4'd2;
      #1;
      rst = 1'b1;
      #1;
      expect_val("arst_count", 16'h0000);    pop_chk(write_count);
      expect_val("arst_halted", 16'h0000);   pop_chk({15'b0, halted});
      expect_val("arst_r7", 16'h0000);       pop_chk(SrcData1);
      tick();
      rst = 1'b0; bubble(); #1;
      expect_val("arst_r2", 16'h0000);       pop_chk(SrcData2);
      expect_val("arst_count2", 16'h0000);   pop_chk(write_count);

      // Drive write_count up to 0xFFFE, then three more commits must saturate
      RegWrite = 1'b1; DstReg = 4'd1;
      for (int i = 0; i < 65534; i++) begin
         reg_data = i[15:0];
         @(posedge clk);
      end
      @(negedge clk);
      bubble(); #1;
      expect_val("preload_count", 16'hFFFE); pop_chk(write_count);
      SrcReg1 = 4'd1; #1;
      expect_val("preload_r1", 16'hFFFD);    pop_chk(SrcData1);
      for (int i = 0; i < 3; i++) begin
         RegWrite = 1'b1; reg_data = 16'h5000 + 16'(i);
         tick();
         bubble(); #1;
         expect_val("sat_count", 16'hFFFF);  pop_chk(write_count);
      end
      expect_val("sat_r1", 16'h5002);        pop_chk(SrcData1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter: ZERO_REG, default 1, meaning: when 1, register 0 reads as 0x0000 and ignores writes.
REQ-002 Clock, reset and port names follow the codebase: clk in 1, the single clock; all state updates on rising edge.
REQ-003 rst in 1, reset, asynchronous and active-high.
REQ-004 RegWrite in 1, write-back enable from the MEM/WB stage.
REQ-005 MemtoReg in 1, selects dmem_data as the write data.
REQ-006 PCtoReg in 1, selects PC as the write data (PCS instruction).
REQ-007 Halt in 1, the HLT instruction has reached write-back.
REQ-008 reg_data in 16, ALU result.
REQ-009 dmem_data in 16, load data.
REQ-010 PC in 16, forwarded PC value for PCS.
REQ-011 DstReg in 4, destination register index.
REQ-012 SrcReg1, SrcReg2 in 4 each, decode-stage read indices.
REQ-013 SrcData1, SrcData2 out 16 each, read data.
REQ-014 wb_data out 16, selected write-back value; combinational.
REQ-015 halted out 1, sticky halt status.
REQ-016 write_count out 16, number of committed register writes.

Function
REQ-017 The write-data select SHALL use this priority: PCtoReg gives PC; otherwise MemtoReg gives dmem_data; otherwise reg_data.
REQ-018 A write commits on a rising edge only when RegWrite=1, halted=0, and not (ZERO_REG=1 and DstReg=0).
  - Effect: reg[DstReg] takes wb_data.
REQ-019 Reads SHALL be combinational.
REQ-020 Read bypass: when a write is committing this cycle and SrcRegN equals DstReg, SrcDataN SHALL equal wb_data in the same cycle (write-before-read).
REQ-021 With ZERO_REG=1, SrcReg=0 SHALL return 0x0000 regardless of any bypass condition.
REQ-022 Halt SHALL set halted on the rising edge where Halt=1.
  - halted holds 1 until reset.
  - Writes are blocked from the cycle after that edge onward.
  - A RegWrite presented in the same cycle as Halt still commits.
REQ-023 write_count SHALL increment by 1 on every committed write.
  - It saturates at 0xFFFF with no wrap-around.
REQ-024 A bubble (all control inputs 0) SHALL cause no state change.
REQ-025 Read-to-data latency is 0 cycles; write-to-architectural-state latency is 1 edge.

Reset
REQ-026 Asserting rst SHALL immediately clear, without waiting for clk:
  - all 16 registers to 0x0000,
  - halted to 0,
  - write_count to 0x0000.
REQ-027 When rst coincides with a committing write, reset SHALL win: the register remains 0x0000 and write_count remains 0.
REQ-028 The first write SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-029 A shared package SHALL hold the following, for reuse by the MEM/WB register and the hazard unit:
  - DATA_W=16 and REG_IDX_W=4,
  - the WB control bit order {RegWrite, MemtoReg, PCtoReg, Halt}.
REQ-030 Each register SHALL be one instance of the existing Bit16Reg sub-module, with write_en decoded from DstReg.
  - The halt flag and write_count are local flops in this module.

Verification
REQ-031 Write then read:
  - Stimulus: RegWrite=1, DstReg=3, reg_data=0x1234.
  - Response: next cycle SrcReg1=3 gives SrcData1=0x1234; write_count=1.
REQ-032 Data select and bypass:
  - Stimulus: RegWrite=1, MemtoReg=1, PCtoReg=1, PC=0x0042, dmem_data=0xBEEF, DstReg=5, SrcReg2=5, all in the same cycle.
  - Response: SrcData2=0x0042 combinationally; afterwards reg5=0x0042.
REQ-033 Zero register:
  - Stimulus: RegWrite=1, DstReg=0, reg_data=0xFFFF.
  - Response: SrcData1 for SrcReg1=0 is 0x0000 both in the write cycle and after; write_count is unchanged.
REQ-034 Halt:
  - Stimulus: Halt=1 together with RegWrite=1, DstReg=7, reg_data=0x0007; the next cycle RegWrite=1, DstReg=7, reg_data=0x0099.
  - Response: reg7=0x0007; halted=1 persists; write_count=1.
REQ-035 Async reset mid-write:
  - Stimulus: rst pulsed between clock edges while RegWrite=1, DstReg=2.
  - Response: outputs clear before the next edge; reg2=0x0000 after the edge on which rst was still asserted.
REQ-036 Saturation:
  - Stimulus: preload write_count to 0xFFFE, then perform 3 committed writes.
  - Response: write_count=0xFFFF and it does not wrap.
